// File: rtl/axil_cfg_sequencer.sv
// axil_cfg_sequencer: AXI4-Lite master that runs one queued register command at a time
// (write or read, with a pre-issue delay) and returns one response record per command.
// Optional watchdog enabled by defining LITE_SEQ_TIMEOUT_EN.
module axil_cfg_sequencer #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 9,
    parameter int DELAY_WIDTH        = 16,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_S_AXI_ADDR_WIDTH-3:0]     cmd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     cmd_data,
    input  logic [DELAY_WIDTH-1:0]            cmd_delay,
    output logic                              rsp_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     rsp_data,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic                              busy,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef LITE_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, DELAY, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t                        state, state_nx;
    logic                          rdy_q, wr_q, aw_done, w_done, tmo_q, tmo_hit, active;
    logic [C_S_AXI_ADDR_WIDTH-3:0] addr_q;
    logic [DW-1:0]                 data_q, rdata_q;
    logic [DELAY_WIDTH-1:0]        cnt_q;
    logic [1:0]                    resp_q;
    logic [WW-1:0]                 wd_q;

    assign active       = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_RESP);
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state selection, watchdog abort and all state-derived outputs
    always_comb begin
        state_nx = state;
        tmo_hit  = 1'b0;
        case (state)
            IDLE:    if (cmd_valid && rdy_q) state_nx = (cmd_delay != '0) ? DELAY : (cmd_write ? WR_REQ : RD_REQ);
            DELAY:   if (cnt_q <= DELAY_WIDTH'(1)) state_nx = wr_q ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) state_nx = WR_RESP;
            WR_RESP: if (M_AXI_BVALID) state_nx = DONE;
            RD_REQ:  if (M_AXI_ARREADY) state_nx = RD_RESP;
            RD_RESP: if (M_AXI_RVALID) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (TMO_EN && active && state_nx == state && wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
            tmo_hit  = 1'b1;
            state_nx = DONE;
        end
        cmd_ready     = (state == IDLE) && rdy_q;
        busy          = state != IDLE;
        M_AXI_AWVALID = (state == WR_REQ) && !aw_done;
        M_AXI_WVALID  = (state == WR_REQ) && !w_done;
        M_AXI_AWADDR  = ((state == WR_REQ) && !aw_done) ? {addr_q, 2'b00} : '0;
        M_AXI_WDATA   = ((state == WR_REQ) && !w_done) ? data_q : '0;
        M_AXI_BREADY  = state == WR_RESP;
        M_AXI_ARVALID = state == RD_REQ;
        M_AXI_ARADDR  = (state == RD_REQ) ? {addr_q, 2'b00} : '0;
        M_AXI_RREADY  = state == RD_RESP;
        rsp_valid     = state == DONE;
        rsp_data      = (state == DONE) ? rdata_q : '0;
        rsp_resp      = (state == DONE) ? resp_q : 2'b00;
        rsp_timeout   = TMO_EN && (state == DONE) && tmo_q;
    end

    // Command latch, delay countdown, per-channel completion flags and response capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
            tmo_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (state == IDLE && cmd_valid && rdy_q) begin
                wr_q    <= cmd_write;
                addr_q  <= cmd_addr;
                data_q  <= cmd_data;
                cnt_q   <= cmd_delay;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                rdata_q <= '0;
                resp_q  <= 2'b00;
                tmo_q   <= 1'b0;
            end
            if (state == DELAY) cnt_q <= cnt_q - DELAY_WIDTH'(1);
            if (state == WR_REQ) begin
                aw_done <= aw_done | M_AXI_AWREADY;
                w_done  <= w_done | M_AXI_WREADY;
            end
            if (state == WR_RESP && M_AXI_BVALID) resp_q <= M_AXI_BRESP;
            if (state == RD_RESP && M_AXI_RVALID) begin
                rdata_q <= M_AXI_RDATA;
                resp_q  <= M_AXI_RRESP;
            end
            if (tmo_hit) begin
                tmo_q   <= 1'b1;
                resp_q  <= 2'b10;
                rdata_q <= '0;
            end
        end
    end

    // Watchdog: counts cycles spent in one bus state, restarting on every state change
    always_ff @(posedge clk) begin
        if (!rst_n || state_nx != state || !active) wd_q <= '0;
        else                                        wd_q <= wd_q + WW'(1);
    end
endmodule
